// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for single-digit ASCII infix expressions
// built from digits, '+' and '*'. '*' binds tighter than '+'. One character
// is consumed per clock when in_valid is high. result tracks the value of the
// longest legal prefix seen so far.
//
// Ports:
//   clk      - rising-edge clock
//   clr      - asynchronous active-high reset
//   in       - ASCII character
//   in_valid - character in `in` is consumed on this edge
//   result   - value of the most recent legal prefix (sum + current product)
//   legal    - stream is currently a complete legal expression
//   err      - sticky: a malformed character has been seen since clr
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             legal,
  output logic             err
);

  typedef enum logic [1:0] {EXP_D, EXP_O, ERR} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sum, sum_nxt;
  logic [WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             legal_nxt, err_nxt;

  logic             is_dig, is_add, is_mul;
  logic [WIDTH-1:0] digit;
  logic [WIDTH-1:0] prod_dig;

  // Character decode and the digit-scaled product (truncated to WIDTH).
  always_comb begin
    is_dig     = (in >= 8'h30) && (in <= 8'h39);
    is_add     = (in == 8'h2B);
    is_mul     = (in == 8'h2A);
    digit      = '0;
    digit[3:0] = in[3:0];
    prod_dig   = prod * digit;
  end

  always_comb begin
    state_nxt  = state;
    sum_nxt    = sum;
    prod_nxt   = prod;
    result_nxt = result;
    legal_nxt  = legal;
    err_nxt    = err;
    if (in_valid) begin
      unique case (state)
        EXP_D: begin
          if (is_dig) begin
            prod_nxt   = prod_dig;
            result_nxt = sum + prod_dig;
            legal_nxt  = 1'b1;
            state_nxt  = EXP_O;
          end else begin
            legal_nxt  = 1'b0;
            err_nxt    = 1'b1;
            state_nxt  = ERR;
          end
        end
        EXP_O: begin
          if (is_add) begin
            sum_nxt   = sum + prod;
            prod_nxt  = ONE;
            legal_nxt = 1'b0;
            state_nxt = EXP_D;
          end else if (is_mul) begin
            legal_nxt = 1'b0;
            state_nxt = EXP_D;
          end else begin
            legal_nxt = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = ERR;
          end
        end
        ERR: begin
          state_nxt = ERR;
        end
        default: begin
          state_nxt = ERR;
          legal_nxt = 1'b0;
          err_nxt   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= EXP_D;
      sum    <= '0;
      prod   <= ONE;
      result <= '0;
      legal  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      sum    <= sum_nxt;
      prod   <= prod_nxt;
      result <= result_nxt;
      legal  <= legal_nxt;
      err    <= err_nxt;
    end
  end

endmodule
